traffic_phase_scheduler: RTL and testbench

//   Demand-driven phase scheduler for one two-road intersection with an optional pedestrian phase.
//   It decides which road gets green and for how long, using min/max green, yellow, all-red and

---
 rtl/traffic_phase_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// Module   : traffic_phase_scheduler
// Brief    : Demand-driven phase scheduler for a two-road intersection, with
//            run-time programmable green/yellow/all-red/walk durations.
//            Timing advances only on the 1-cycle tick strobe.
//            Optional pedestrian phase is enabled by defining TRAFFIC_PED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_scheduler #(
    parameter int CW       = 6,
    parameter int GMIN_DEF = 10,
    parameter int GMAX_DEF = 30,
    parameter int YEL_DEF  = 5,
    parameter int ARED_DEF = 2,
    parameter int WALK_DEF = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          tick,
    input  logic          ns_req,
    input  logic          ew_req,
    input  logic          ped_req,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic [1:0]    NS,
    output logic [1:0]    EW,
    output logic          WALK,
    output logic [2:0]    phase,
    output logic          ped_pending
);

    typedef enum logic [2:0] {
        S_NS_G = 3'd0,
        S_NS_Y = 3'd1,
        S_ARED = 3'd2,
        S_EW_G = 3'd3,
        S_EW_Y = 3'd4,
        S_PED  = 3'd5
    } state_t;

    localparam logic [1:0]    c_RED = 2'd0;
    localparam logic [1:0]    c_YEL = 2'd1;
    localparam logic [1:0]    c_GRN = 2'd2;
    localparam logic [CW-1:0] c_ONE = CW'(1);

    state_t        r_state;
    state_t        w_next;
    logic          r_last;          // last served road: 0 = NS, 1 = EW
    logic          w_last;
    logic [CW-1:0] r_count;
    logic [CW:0]   w_cnt1;          // count+1 one bit wider so saturation never wraps
    logic [1:0]    r_ns;
    logic [1:0]    r_ew;
    logic          r_walk;
    logic          w_ped_pending;

    logic [CW-1:0] r_green_min;
    logic [CW-1:0] r_green_max;
    logic [CW-1:0] r_yellow;
    logic [CW-1:0] r_all_red;

    // A programmed duration of zero behaves as one tick
    function automatic logic [CW:0] f_dur(input logic [CW-1:0] d);
        f_dur = (d == '0) ? {1'b0, c_ONE} : {1'b0, d};
    endfunction

    function automatic logic [1:0] f_ns_light(input state_t s);
        case (s)
            S_NS_G:  f_ns_light = c_GRN;
            S_NS_Y:  f_ns_light = c_YEL;
            default: f_ns_light = c_RED;
        endcase
    endfunction

    function automatic logic [1:0] f_ew_light(input state_t s);
        case (s)
            S_EW_G:  f_ew_light = c_GRN;
            S_EW_Y:  f_ew_light = c_YEL;
            default: f_ew_light = c_RED;
        endcase
    endfunction

`ifdef TRAFFIC_PED_EN
    logic [CW-1:0] r_walk_dur;
    logic          r_ped_pending;
`else
    logic          w_unused_ped;
    assign w_unused_ped = ped_req;
`endif

    // Run-time configuration registers, reloaded with defaults on clear
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_green_min <= CW'(GMIN_DEF);
            r_green_max <= CW'(GMAX_DEF);
            r_yellow    <= CW'(YEL_DEF);
            r_all_red   <= CW'(ARED_DEF);
`ifdef TRAFFIC_PED_EN
            r_walk_dur  <= CW'(WALK_DEF);
`endif
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    r_green_min <= cfg_data;
                3'd1:    r_green_max <= cfg_data;
                3'd2:    r_yellow    <= cfg_data;
                3'd3:    r_all_red   <= cfg_data;
`ifdef TRAFFIC_PED_EN
                3'd4:    r_walk_dur  <= cfg_data;
`endif
                default: ;
            endcase
        end
    end

    assign w_cnt1 = {1'b0, r_count} + {1'b0, c_ONE};

    // Next-state decision; every transition is gated by a tick
    always_comb begin
        w_next = r_state;
        w_last = r_last;
        if (tick) begin
            case (r_state)
                S_NS_G: begin
                    if ((w_cnt1 >= f_dur(r_green_max)) ||
                        ((w_cnt1 >= f_dur(r_green_min)) && (ew_req || w_ped_pending)))
                        w_next = S_NS_Y;
                end
                S_EW_G: begin
                    if ((w_cnt1 >= f_dur(r_green_max)) ||
                        ((w_cnt1 >= f_dur(r_green_min)) && (ns_req || w_ped_pending)))
                        w_next = S_EW_Y;
                end
                S_NS_Y: begin
                    if (w_cnt1 >= f_dur(r_yellow)) begin
                        w_next = S_ARED;
                        w_last = 1'b0;
                    end
                end
                S_EW_Y: begin
                    if (w_cnt1 >= f_dur(r_yellow)) begin
                        w_next = S_ARED;
                        w_last = 1'b1;
                    end
                end
                S_ARED: begin
                    if (w_cnt1 >= f_dur(r_all_red)) begin
                        if (w_ped_pending)
                            w_next = S_PED;
                        else
                            w_next = r_last ? S_NS_G : S_EW_G;
                    end
                end
`ifdef TRAFFIC_PED_EN
                S_PED: begin
                    if (w_cnt1 >= f_dur(r_walk_dur))
                        w_next = S_ARED;
                end
`endif
                default: w_next = S_NS_G;
            endcase
        end
    end

    // State, last road, phase counter and lamp outputs registered together
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_NS_G;
            r_last  <= 1'b0;
            r_count <= '0;
            r_ns    <= c_GRN;
            r_ew    <= c_RED;
            r_walk  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_last  <= w_last;
            if (w_next != r_state)
                r_count <= '0;
            else if (tick && (r_count != '1))
                r_count <= r_count + c_ONE;
            r_ns    <= f_ns_light(w_next);
            r_ew    <= f_ew_light(w_next);
            r_walk  <= (w_next == S_PED);
        end
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian latch; clearing on PED entry takes priority over a new press
    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            r_ped_pending <= 1'b0;
        else if ((r_state == S_ARED) && (w_next == S_PED))
            r_ped_pending <= 1'b0;
        else if (ped_req)
            r_ped_pending <= 1'b1;
    end
    assign w_ped_pending = r_ped_pending;
    assign WALK          = r_walk;
`else
    assign w_ped_pending = 1'b0;
    assign WALK          = 1'b0;
`endif

    assign NS          = r_ns;
    assign EW          = r_ew;
    assign phase       = r_state;
    assign ped_pending = w_ped_pending;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ============================================================================
// Module   : tb_traffic_phase_scheduler
// Brief    : Directed self-checking bench for traffic_phase_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_scheduler;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          clear;
    logic          tick;
    logic          ns_req;
    logic          ew_req;
    logic          ped_req;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic [1:0]    NS;
    logic [1:0]    EW;
    logic          WALK;
    logic [2:0]    phase;
    logic          ped_pending;

    int n_checks = 0;
    int n_fails  = 0;

    traffic_phase_scheduler #(.CW(CW)) dut (
        .clk         (clk),
        .clear       (clear),
        .tick        (tick),
        .ns_req      (ns_req),
        .ew_req      (ew_req),
        .ped_req     (ped_req),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .NS          (NS),
        .EW          (EW),
        .WALK        (WALK),
        .phase       (phase),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock, then settle 1 time unit past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until phase changes; returns the number of steps (bounded)
    task automatic run_phase(output int n);
        logic [2:0] p0;
        p0 = phase;
        n  = 0;
        while ((phase == p0) && (n < 200)) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [CW-1:0] d);
        tick     = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
        tick     = 1'b1;
    endtask

    task automatic check_lights(input string tag, input int ns, input int ew, input int ph);
        check_val({tag, "_ns"}, NS, ns);
        check_val({tag, "_ew"}, EW, ew);
        check_val({tag, "_phase"}, phase, ph);
    endtask

    initial begin
        int n;
        int changes;
        clear = 1'b1; tick = 1'b1; ns_req = 1'b0; ew_req = 1'b1; ped_req = 1'b0;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = '0;

        // Reset state
        step();
        check_lights("rst", 2, 0, 0);
        check_val("rst_walk", WALK, 0);
        check_val("rst_pedp", ped_pending, 0);
        clear = 1'b0;

        // Test 1: EW demand, defaults
        run_phase(n); check_val("t1_nsg_len", n, 10); check_lights("t1_nsy", 1, 0, 1);
        run_phase(n); check_val("t1_nsy_len", n, 5);  check_lights("t1_ared", 0, 0, 2);
        run_phase(n); check_val("t1_ared_len", n, 2); check_lights("t1_ewg", 0, 2, 3);

        // Test 2: no demand, rest in green until green_max
        ew_req = 1'b0;
        do_reset();
        run_phase(n); check_val("t2_nsg_len", n, 30); check_lights("t2_nsy", 1, 0, 1);
        run_phase(n); check_val("t2_nsy_len", n, 5);
        run_phase(n); check_val("t2_ared_len", n, 2); check_lights("t2_ewg", 0, 2, 3);

        // Test 3: pedestrian pulse in NS_G, no vehicle demand
        do_reset();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
`ifdef TRAFFIC_PED_EN
        check_val("t3_pedp_set", ped_pending, 1);
        run_phase(n); check_val("t3_nsg_len", n + 1, 10);
        run_phase(n); check_val("t3_nsy_len", n, 5);
        run_phase(n); check_val("t3_ared1_len", n, 2);
        check_lights("t3_ped", 0, 0, 5);
        check_val("t3_walk_on", WALK, 1);
        check_val("t3_pedp_clr", ped_pending, 0);
        run_phase(n); check_val("t3_ped_len", n, 8);
        check_val("t3_walk_off", WALK, 0);
        run_phase(n); check_val("t3_ared2_len", n, 2);
        check_lights("t3_ewg", 0, 2, 3);
`else
        check_val("t3_pedp_ignored", ped_pending, 0);
        run_phase(n); check_val("t3_nsg_len", n + 1, 30);
        check_val("t3_walk_off", WALK, 0);
`endif

        // Test 4: shrink green_min mid-phase, then zero yellow
        ew_req = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check_val("t4_still_nsg", phase, 0);
        cfg_write(3'd0, 6'd3);
        check_val("t4_frozen", phase, 0);
        step();
        check_val("t4_to_nsy", phase, 1);
        cfg_write(3'd2, 6'd0);
        step();
        check_val("t4_yel_1tick", phase, 2);

        // Test 5: clear asserted mid EW_Y (green_min still 3)
        ew_req = 1'b0; ns_req = 1'b1;
        run_phase(n); check_val("t4_ared_len", n, 2); check_val("t5_ewg", phase, 3);
        run_phase(n); check_val("t5_ewg_len", n, 3);  check_lights("t5_ewy", 0, 1, 4);
        clear = 1'b1;
        #2;
        check_lights("t5_async", 2, 0, 0);
        check_val("t5_async_walk", WALK, 0);
        step();
        clear = 1'b0; ns_req = 1'b0; ew_req = 1'b1;
        run_phase(n); check_val("t5_defaults_gmin", n, 10);
        run_phase(n); check_val("t5_defaults_yel", n, 5);

        // green_max below green_min: green_max wins
        ew_req = 1'b0;
        do_reset();
        cfg_write(3'd0, 6'd20);
        cfg_write(3'd1, 6'd4);
        run_phase(n); check_val("gmax_wins_len", n, 4);

        // Test 6: tick frozen for 100 cycles
        ew_req = 1'b1;
        do_reset();
        tick = 1'b0;
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            ped_req = (i == 50);
            step();
            if (phase != 3'd0) changes++;
        end
        ped_req = 1'b0;
        check_val("t6_no_change", changes, 0);
`ifdef TRAFFIC_PED_EN
        check_val("t6_pedp_latched", ped_pending, 1);
`else
        check_val("t6_pedp_ignored", ped_pending, 0);
`endif
        tick = 1'b1;
        run_phase(n); check_val("t6_resume_len", n, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
